env_step: RTL and testbench

ENV_STEP -- requirements
Module: env_step

---
 rtl/env_step.sv | 177 +++++++++++++++++
 tb/tb_env_step.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/env_step.sv
// Grid-world environment step engine.
// Accepts a (x, y, action) request, fetches the reward word from an external
// rtable, computes the next grid position with wall clamping and goal
// detection, and tracks the number of steps taken in the current episode.
module env_step #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_STEPS  = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [7:0]            i_x,
    input  logic [7:0]            i_y,
    input  logic [2:0]            i_action,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic                  o_rread,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [7:0]            o_nx,
    output logic [7:0]            o_ny,
    output logic [DATA_WIDTH-1:0] o_reward,
    output logic                  o_wall,
    output logic                  o_goal,
    output logic                  o_done,
    output logic [15:0]           o_step_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic       accept;
    logic       handshake;

    // Request fields captured on accept; the live inputs are ignored afterwards.
    logic [7:0] x_q;
    logic [7:0] y_q;
    logic [2:0] a_q;

    // Geometry for the latched request.
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic [8:0]        nx9;
    logic [8:0]        ny9;
    logic              geo_wall;
    logic [7:0]        geo_nx;
    logic [7:0]        geo_ny;
    logic              geo_goal;
    logic              last_step;

    assign accept    = (state == IDLE) && i_valid;
    assign handshake = (state == OUT) && i_ready;
    assign last_step = (o_step_cnt == 16'(MAX_STEPS - 1));

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake/strobe outputs.
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_rread   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                o_rread   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                state_nxt = OUT;
            end
            OUT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Move decode and 9-bit signed next-position arithmetic; bit 8 set means
    // the coordinate left 0..255 (either -1 or 256), which is a wall hit.
    always_comb begin
        dx = 9'sd0;
        dy = 9'sd0;
        case (a_q)
            3'd0: begin dx = -9'sd1; dy =  9'sd0; end
            3'd1: begin dx = -9'sd1; dy = -9'sd1; end
            3'd2: begin dx =  9'sd0; dy = -9'sd1; end
            3'd3: begin dx =  9'sd1; dy = -9'sd1; end
            3'd4: begin dx =  9'sd1; dy =  9'sd0; end
            3'd5: begin dx =  9'sd1; dy =  9'sd1; end
            3'd6: begin dx =  9'sd0; dy =  9'sd1; end
            3'd7: begin dx = -9'sd1; dy =  9'sd1; end
            default: begin dx = 9'sd0; dy = 9'sd0; end
        endcase
        nx9      = {1'b0, x_q} + dx;
        ny9      = {1'b0, y_q} + dy;
        geo_wall = nx9[8] | ny9[8];
        geo_nx   = geo_wall ? x_q : nx9[7:0];
        geo_ny   = geo_wall ? y_q : ny9[7:0];
        geo_goal = !geo_wall && (geo_nx == 8'hFF) && (geo_ny == 8'hFF);
    end

    // Request capture and rtable address; the address register loads on the
    // accept edge so it is already presented throughout ISSUE and then holds.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_q     <= '0;
            y_q     <= '0;
            a_q     <= '0;
            o_raddr <= '0;
        end else if (accept) begin
            x_q     <= i_x;
            y_q     <= i_y;
            a_q     <= i_action;
            o_raddr <= ADDR_WIDTH'({i_x, i_y, i_action});
        end
    end

    // Result registers: loaded when leaving WAIT, held stable through OUT.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_reward <= '0;
            o_nx     <= '0;
            o_ny     <= '0;
            o_wall   <= 1'b0;
            o_goal   <= 1'b0;
            o_done   <= 1'b0;
        end else if (state == WAIT) begin
            o_reward <= i_rdata;
            o_nx     <= geo_nx;
            o_ny     <= geo_ny;
            o_wall   <= geo_wall;
            o_goal   <= geo_goal;
            o_done   <= geo_goal | last_step;
        end
    end

    // Episode step counter, advanced on the result handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_step_cnt <= '0;
        end else if (handshake) begin
            if (o_done) begin
                o_step_cnt <= '0;
            end else begin
                o_step_cnt <= o_step_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_env_step.sv
// Directed bench for env_step with a small episode limit (MAX_STEPS = 4).
module tb_env_step;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_x;
    logic [7:0]  i_y;
    logic [2:0]  i_action;
    logic [18:0] o_raddr;
    logic        o_rread;
    logic [31:0] i_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_nx;
    logic [7:0]  o_ny;
    logic [31:0] o_reward;
    logic        o_wall;
    logic        o_goal;
    logic        o_done;
    logic [15:0] o_step_cnt;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [15:0] exp_cnt;
    logic [31:0] rd_value;
    logic [18:0] last_raddr;

    env_step #(
        .ADDR_WIDTH(19),
        .DATA_WIDTH(32),
        .MAX_STEPS (4)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_x       (i_x),
        .i_y       (i_y),
        .i_action  (i_action),
        .o_raddr   (o_raddr),
        .o_rread   (o_rread),
        .i_rdata   (i_rdata),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_nx      (o_nx),
        .o_ny      (o_ny),
        .o_reward  (o_reward),
        .o_wall    (o_wall),
        .o_goal    (o_goal),
        .o_done    (o_done),
        .o_step_cnt(o_step_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // rtable model: one-cycle read latency, junk data when not strobed.
    always @(posedge i_clk) begin
        i_rdata <= o_rread ? rd_value : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_ready",  o_ready,    1);
        check("rst_valid",  o_valid,    0);
        check("rst_rread",  o_rread,    0);
        check("rst_raddr",  o_raddr,    0);
        check("rst_reward", o_reward,   0);
        check("rst_nx",     o_nx,       0);
        check("rst_ny",     o_ny,       0);
        check("rst_wall",   o_wall,     0);
        check("rst_goal",   o_goal,     0);
        check("rst_done",   o_done,     0);
        check("rst_cnt",    o_step_cnt, 0);
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check_reset_values();
        @(negedge i_clk);
        i_rst   = 1'b0;
        exp_cnt = '0;
    endtask

    // One full step; expected geometry is supplied by the caller, done is
    // goal or the fourth step of the episode.
    task automatic do_step(input logic [7:0] x, input logic [7:0] y, input logic [2:0] a,
                           input logic [31:0] rd, input logic [7:0] enx, input logic [7:0] eny,
                           input logic ewall, input logic egoal, input int hold);
        logic        edone;
        logic [18:0] eaddr;
        eaddr    = {x, y, a};
        edone    = egoal || (exp_cnt == 16'd3);
        rd_value = rd;
        @(negedge i_clk);
        check("ready_idle", o_ready, 1);
        i_valid  = 1'b1;
        i_x      = x;
        i_y      = y;
        i_action = a;
        @(negedge i_clk);
        i_x      = ~x;
        i_y      = ~y;
        i_action = ~a;
        check("rread_issue", o_rread, 1);
        check("raddr_issue", o_raddr, eaddr);
        check("ready_busy",  o_ready, 0);
        check("valid_issue", o_valid, 0);
        last_raddr = o_raddr;
        @(negedge i_clk);
        check("rread_wait", o_rread, 0);
        check("valid_wait", o_valid, 0);
        @(negedge i_clk);
        check("valid_out",  o_valid,    1);
        check("rread_out",  o_rread,    0);
        check("raddr_hold", o_raddr,    eaddr);
        check("nx",         o_nx,       enx);
        check("ny",         o_ny,       eny);
        check("wall",       o_wall,     ewall);
        check("goal",       o_goal,     egoal);
        check("done",       o_done,     edone);
        check("reward",     o_reward,   rd);
        check("cnt_out",    o_step_cnt, exp_cnt);
        for (int i = 0; i < hold; i++) begin
            @(negedge i_clk);
            check("bp_valid",  o_valid,    1);
            check("bp_ready",  o_ready,    0);
            check("bp_nx",     o_nx,       enx);
            check("bp_ny",     o_ny,       eny);
            check("bp_reward", o_reward,   rd);
            check("bp_done",   o_done,     edone);
            check("bp_cnt",    o_step_cnt, exp_cnt);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check("ready_after", o_ready, 1);
        check("valid_after", o_valid, 0);
        exp_cnt = edone ? 16'd0 : exp_cnt + 16'd1;
        check("step_cnt", o_step_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_cnt    = '0;
        rd_value   = '0;
        last_raddr = '0;
        i_rst      = 1'b1;
        i_valid    = 1'b0;
        i_ready    = 1'b0;
        i_x        = '0;
        i_y        = '0;
        i_action   = '0;
        repeat (2) @(negedge i_clk);
        check_reset_values();
        i_rst = 1'b0;

        // Interior, wall corner, goal, backpressure and edge walls.
        do_step(8'd10,  8'd20,  3'd5, 32'h1234_5678, 8'd11,  8'd21,  1'b0, 1'b0, 0);
        check("raddr_0a145", last_raddr, 19'h050A5);
        do_step(8'd0,   8'd0,   3'd1, 32'hFFFF_FFFF, 8'd0,   8'd0,   1'b1, 1'b0, 0);
        do_step(8'd254, 8'd254, 3'd5, 32'hFFFF_FFFF, 8'd255, 8'd255, 1'b0, 1'b1, 0);
        check("raddr_goal", last_raddr, 19'h7F7F5);
        do_step(8'd100, 8'd50,  3'd0, 32'h0000_0064, 8'd99,  8'd50,  1'b0, 1'b0, 5);
        do_step(8'd255, 8'd10,  3'd4, 32'h0000_0005, 8'd255, 8'd10,  1'b1, 1'b0, 0);
        do_step(8'd5,   8'd0,   3'd2, 32'h8000_0001, 8'd5,   8'd0,   1'b1, 1'b0, 0);
        // Wall at (255,255) is not a goal, but this is the 4th step.
        do_step(8'd255, 8'd255, 3'd6, 32'h0000_0007, 8'd255, 8'd255, 1'b1, 1'b0, 1);

        // All eight moves from (50,50); episode limit hits on 4th and 8th.
        apply_reset();
        do_step(8'd50, 8'd50, 3'd0, 32'h0000_0100, 8'd49, 8'd50, 1'b0, 1'b0, 0);
        do_step(8'd50, 8'd50, 3'd1, 32'h0000_0101, 8'd49, 8'd49, 1'b0, 1'b0, 0);
        do_step(8'd50, 8'd50, 3'd2, 32'h0000_0102, 8'd50, 8'd49, 1'b0, 1'b0, 0);
        do_step(8'd50, 8'd50, 3'd3, 32'h0000_0103, 8'd51, 8'd49, 1'b0, 1'b0, 0);
        do_step(8'd50, 8'd50, 3'd4, 32'h0000_0104, 8'd51, 8'd50, 1'b0, 1'b0, 0);
        do_step(8'd50, 8'd50, 3'd5, 32'h0000_0105, 8'd51, 8'd51, 1'b0, 1'b0, 0);
        do_step(8'd50, 8'd50, 3'd6, 32'h0000_0106, 8'd50, 8'd51, 1'b0, 1'b0, 0);
        do_step(8'd50, 8'd50, 3'd7, 32'h0000_0107, 8'd49, 8'd51, 1'b0, 1'b0, 0);
        check("cnt_after_limit", o_step_cnt, 16'd0);

        // Reset during WAIT aborts the step and clears the count.
        do_step(8'd7, 8'd7, 3'd4, 32'h0000_0042, 8'd8, 8'd7, 1'b0, 1'b0, 0);
        rd_value = 32'h0BAD_0BAD;
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_x      = 8'd30;
        i_y      = 8'd40;
        i_action = 3'd4;
        @(negedge i_clk);
        i_valid = 1'b0;
        check("abort_issue", o_rread, 1);
        @(negedge i_clk);
        check("abort_wait_valid", o_valid, 0);
        i_rst = 1'b1;
        #1;
        check_reset_values();
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("abort_no_valid", o_valid, 0);
        end
        i_rst   = 1'b0;
        exp_cnt = '0;
        @(negedge i_clk);
        check("abort_no_valid_post", o_valid, 0);
        check("abort_cnt", o_step_cnt, 0);
        do_step(8'd30, 8'd40, 3'd4, 32'h0000_0077, 8'd31, 8'd40, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
